// File: rtl/fpu_pkg.sv
// Shared FPU definitions: add-class op encoding, issue FIFO depth and
// IEEE-754 single-precision field positions.
package fpu_pkg;

  typedef enum logic [1:0] {
    FOP_ADD = 2'b00,
    FOP_SUB = 2'b01,
    FOP_NEG = 2'b10,
    FOP_ABS = 2'b11
  } fop_addsub_t;

  localparam int FADD_ISSUE_DEPTH = 2;

  localparam int FP_SIGN   = 31;
  localparam int FP_EXP_HI = 30;
  localparam int FP_EXP_LO = 23;

  // fadd treats exponent 0 as zero, so denormal payloads are dropped here.
  function automatic logic [31:0] fp_zero_flush(input logic [31:0] v);
    logic [31:0] r;
    if (v[FP_EXP_HI:FP_EXP_LO] == 8'd0)
      r = {v[FP_SIGN], 31'd0};
    else
      r = v;
    return r;
  endfunction

endpackage

// File: rtl/fadd_operand_fmt.sv
// Rewrites one operand pair so a plain adder yields FADD/FSUB/FNEG/FABS,
// then flushes exponent-0 operands to signed zero.
module fadd_operand_fmt
  import fpu_pkg::*;
(
  input  fop_addsub_t i_op,
  input  logic [31:0] i_x1,
  input  logic [31:0] i_x2,
  output logic [31:0] o_x1,
  output logic [31:0] o_x2
);

  logic [31:0] w_x1;
  logic [31:0] w_x2;

  always_comb begin
    w_x1 = i_x1;
    w_x2 = i_x2;
    unique case (i_op)
      FOP_ADD: ;
      FOP_SUB: w_x2[FP_SIGN] = ~i_x2[FP_SIGN];
      FOP_NEG: begin
        w_x1           = 32'd0;
        w_x2[FP_SIGN]  = ~i_x2[FP_SIGN];
      end
      FOP_ABS: begin
        w_x1           = 32'd0;
        w_x2[FP_SIGN]  = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_x1 = fp_zero_flush(w_x1);
  assign o_x2 = fp_zero_flush(w_x2);

endmodule

// File: rtl/fadd_issue.sv
// Operand issue stage for fadd: rewrite on push, 2-entry circular FIFO.
// Define FADD_ISSUE_BYPASS_EN for a zero-latency path when the FIFO is empty.
module fadd_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_x1,
  output logic [31:0]      out_x2,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       count
);

  logic [31:0]      w_fmt_x1;
  logic [31:0]      w_fmt_x2;
  logic             w_push;
  logic             w_pop;
  logic             w_bypass;

  logic [31:0]      r_x1_mem  [FADD_ISSUE_DEPTH];
  logic [31:0]      r_x2_mem  [FADD_ISSUE_DEPTH];
  logic [TAG_W-1:0] r_tag_mem [FADD_ISSUE_DEPTH];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  fadd_operand_fmt u_fmt (
    .i_op (fop_addsub_t'(in_op)),
    .i_x1 (in_x1),
    .i_x2 (in_x2),
    .o_x1 (w_fmt_x1),
    .o_x2 (w_fmt_x2)
  );

`ifdef FADD_ISSUE_BYPASS_EN
  assign w_bypass = (r_count == 2'd0) && in_valid && out_ready && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // Ready depends only on occupancy, never on out_ready.
  assign in_ready = (r_count != 2'd2);
  assign w_push   = in_valid && in_ready && !flush && !w_bypass;
  assign w_pop    = (r_count != 2'd0) && out_ready && !flush;
  assign count    = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FADD_ISSUE_DEPTH; i++) begin
        r_x1_mem[i]  <= '0;
        r_x2_mem[i]  <= '0;
        r_tag_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_x1_mem[r_wptr]  <= w_fmt_x1;
      r_x2_mem[r_wptr]  <= w_fmt_x2;
      r_tag_mem[r_wptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid = (r_count != 2'd0);
    out_x1    = r_x1_mem[r_rptr];
    out_x2    = r_x2_mem[r_rptr];
    out_tag   = r_tag_mem[r_rptr];
    if (w_bypass) begin
      out_valid = 1'b1;
      out_x1    = w_fmt_x1;
      out_x2    = w_fmt_x2;
      out_tag   = in_tag;
    end
  end

endmodule

// File: tb/tb_fadd_issue.sv
// Directed bench for fadd_issue: queue model checked every cycle plus
// hand-computed literal checks for rewrites, backpressure, flush and reset.
module tb_fadd_issue;

  localparam int TAG_W = 5;
`ifdef FADD_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [1:0]       in_op = 2'd0;
  logic [31:0]      in_x1 = 32'd0;
  logic [31:0]      in_x2 = 32'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_x1;
  logic [31:0]      out_x2;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t q[$];

  fadd_issue #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x1(out_x1), .out_x2(out_x2), .out_tag(out_tag), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec-level op semantics: sign flips/clears on x2, x1 forced to zero,
  // then any exponent-0 value becomes a signed zero.
  function automatic entry_t model_fmt(input logic [1:0] op, input logic [31:0] x1,
                                       input logic [31:0] x2, input logic [TAG_W-1:0] tag);
    entry_t e;
    logic [31:0] a;
    logic [31:0] b;
    a = x1;
    b = x2;
    case (op)
      2'd1: b = x2 ^ 32'h8000_0000;
      2'd2: begin a = 32'd0; b = x2 ^ 32'h8000_0000; end
      2'd3: begin a = 32'd0; b = x2 & 32'h7FFF_FFFF; end
      default: ;
    endcase
    if (((a >> 23) & 32'hFF) == 32'd0) a = a & 32'h8000_0000;
    if (((b >> 23) & 32'hFF) == 32'd0) b = b & 32'h8000_0000;
    e.x1  = a;
    e.x2  = b;
    e.tag = tag;
    return e;
  endfunction

  bit m_byp, m_pop, m_push;

  always @(posedge clk) begin
    if (!rst) begin
      m_byp  = BYP && (q.size() == 0) && in_valid && out_ready && !flush;
      m_pop  = (q.size() != 0) && out_ready && !flush;
      m_push = in_valid && (q.size() < 2) && !flush && !m_byp;
      if (flush) q.delete();
      else begin
        if (m_pop)  void'(q.pop_front());
        if (m_push) q.push_back(model_fmt(in_op, in_x1, in_x2, in_tag));
      end
    end
  end

  always @(posedge rst) q.delete();

  entry_t c_head;
  bit     c_valid;

  always @(negedge clk) begin
    c_valid = (q.size() != 0);
    c_head  = '0;
    if (c_valid) c_head = q[0];
    if (BYP && !c_valid && !rst && in_valid && out_ready && !flush) begin
      c_valid = 1'b1;
      c_head  = model_fmt(in_op, in_x1, in_x2, in_tag);
    end
    check("cmp_out_valid", 64'(out_valid), 64'(c_valid));
    check("cmp_count", 64'(count), 64'(q.size()));
    check("cmp_in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (c_valid) begin
      check("cmp_out_x1", 64'(out_x1), 64'(c_head.x1));
      check("cmp_out_x2", 64'(out_x2), 64'(c_head.x2));
      check("cmp_out_tag", 64'(out_tag), 64'(c_head.tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one op into an empty FIFO, check the rewritten head, then pop it.
  task automatic apply(input string nm, input logic [1:0] op, input logic [31:0] x1,
                       input logic [31:0] x2, input logic [TAG_W-1:0] tag,
                       input logic [31:0] e1, input logic [31:0] e2);
    in_valid = 1'b1; in_op = op; in_x1 = x1; in_x2 = x2; in_tag = tag; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check({nm, "_valid"}, 64'(out_valid), 64'd1);
    check({nm, "_x1"}, 64'(out_x1), 64'(e1));
    check({nm, "_x2"}, 64'(out_x2), 64'(e2));
    check({nm, "_tag"}, 64'(out_tag), 64'(tag));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({nm, "_drained"}, 64'(count), 64'd0);
  endtask

  initial begin
    repeat (3) step();
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_x1", 64'(out_x1), 64'd0);
    rst = 1'b0;
    step();

    apply("fsub", 2'd1, 32'h4040_0000, 32'h3F80_0000, 5'd3, 32'h4040_0000, 32'hBF80_0000);
    apply("fneg", 2'd2, 32'h3F80_0000, 32'h4000_0000, 5'd4, 32'h0000_0000, 32'hC000_0000);
    apply("fabs", 2'd3, 32'h1234_5678, 32'hC000_0000, 5'd5, 32'h0000_0000, 32'h4000_0000);
    apply("fadd_zf", 2'd0, 32'h0012_3456, 32'h8000_0001, 5'd6, 32'h0000_0000, 32'h8000_0000);
    apply("fsub_zf", 2'd1, 32'h3F80_0000, 32'h0000_0005, 5'd7, 32'h3F80_0000, 32'h8000_0000);

    // Backpressure: third op held off until a slot frees.
    out_ready = 1'b0; in_valid = 1'b1; in_op = 2'd0;
    in_x1 = 32'h3F80_0000; in_x2 = 32'h3F80_0000;
    in_tag = 5'd1; step();
    check("bp_count1", 64'(count), 64'd1);
    in_tag = 5'd2; step();
    check("bp_full_ready", 64'(in_ready), 64'd0);
    in_tag = 5'd3; step(); step();
    check("bp_hold_count", 64'(count), 64'd2);
    check("bp_hold_tag", 64'(out_tag), 64'd1);
    out_ready = 1'b1; step();
    check("bp_pop1_count", 64'(count), 64'd1);
    check("bp_pop1_tag", 64'(out_tag), 64'd2);
    step();
    check("bp_pop2_count", 64'(count), 64'd1);
    check("bp_pop2_tag", 64'(out_tag), 64'd3);
    in_valid = 1'b0; step();
    check("bp_empty", 64'(count), 64'd0);
    out_ready = 1'b0;

    // Streaming at count 1.
    in_valid = 1'b1; in_tag = 5'd10; step();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_tag = TAG_W'(10 + i);
      step();
      check("stream_count", 64'(count), 64'd1);
      check("stream_tag", 64'(out_tag), 64'(10 + i));
    end
    in_valid = 1'b0; step();
    out_ready = 1'b0;

    // Flush beats a same-cycle push.
    in_valid = 1'b1; in_tag = 5'd4; step();
    in_tag = 5'd5; step();
    check("fl_pre_count", 64'(count), 64'd2);
    flush = 1'b1; in_tag = 5'd6; step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", 64'(count), 64'd0);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b1; in_tag = 5'd7; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_empty_push", 64'(count), 64'd0);
    step();
    check("fl_stays_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset with two entries held.
    in_valid = 1'b1; in_op = 2'd1; in_x1 = 32'h4040_0000; in_x2 = 32'h3F80_0000;
    in_tag = 5'd8; step();
    in_tag = 5'd9; step();
    check("ar_pre_count", 64'(count), 64'd2);
    #2 rst = 1'b1;
    #1;
    check("ar_count", 64'(count), 64'd0);
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_out_x1", 64'(out_x1), 64'd0);
    check("ar_out_x2", 64'(out_x2), 64'd0);
    check("ar_out_tag", 64'(out_tag), 64'd0);
    check("ar_in_ready", 64'(in_ready), 64'd1);
    step(); step();
    check("ar_push_ignored", 64'(count), 64'd0);
    in_valid = 1'b0; rst = 1'b0;
    step();

`ifdef FADD_ISSUE_BYPASS_EN
    out_ready = 1'b1; in_valid = 1'b1; in_op = 2'd1;
    in_x1 = 32'h4040_0000; in_x2 = 32'h3F80_0000; in_tag = 5'd9;
    #1;
    check("byp_valid", 64'(out_valid), 64'd1);
    check("byp_x2", 64'(out_x2), 64'hBF80_0000);
    check("byp_tag", 64'(out_tag), 64'd9);
    step();
    check("byp_count", 64'(count), 64'd0);
    flush = 1'b1;
    #1;
    check("byp_flush_valid", 64'(out_valid), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
